// File: rtl/ikaopll_acc_postproc.sv
// ikaopll_acc_postproc: post-processing for the OPLL DAC accumulator output.
// It detects the frame strobe edge and runs one sample through FILT -> SAT -> PUSH.
// The output FIFO drives a valid/ready port and has a sticky overflow flag.
// Optional DC blocker: define IKAOPLL_ACC_DCBLOCK_EN to compile in the first-order
// high-pass (pole 1 - 2^-DC_SHIFT). Without it the sample passes through unfiltered,
// but the saturation stage stays so that latency does not change.
module ikaopll_acc_postproc #(
    parameter int FIFO_DEPTH = 4,
    parameter int DC_SHIFT   = 9
) (
    input  logic                          i_EMUCLK,
    input  logic                          i_RST,
    input  logic                          i_ACC_SIGNED_STRB,
    input  logic signed [15:0]            i_ACC_SIGNED,
    output logic signed [15:0]            o_SAMPLE,
    output logic                          o_SAMPLE_VALID,
    input  logic                          i_SAMPLE_READY,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_LEVEL,
    output logic                          o_OVERFLOW,
    input  logic                          i_OVF_CLR
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILT,
        ST_SAT,
        ST_PUSH
    } state_t;

    // Clamp the 18-bit filter result into the 16-bit sample range.
    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sh7FFF;
        else if (v < -18'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    state_t                   state, state_nxt;
    logic                     strb_z;
    logic                     capture;
    logic signed [15:0]       x_p0;
    logic signed [17:0]       y_nxt, y_p1;
    logic signed [15:0]       ys_nxt, ys_p2;

    logic signed [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [LVL_W-1:0]         level;
    logic                     fifo_full, fifo_empty;
    logic                     push_req, push, pop, drop;

    assign capture = i_ACC_SIGNED_STRB & ~strb_z;

    // Strobe delay for rising-edge detection; a strobe held high through reset is not an edge.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) strb_z <= 1'b1;
        else       strb_z <= i_ACC_SIGNED_STRB;
    end

    // FSM state register.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: one clock per stage, only a capture leaves IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (capture) state_nxt = ST_FILT;
            ST_FILT: state_nxt = ST_SAT;
            ST_SAT:  state_nxt = ST_PUSH;
            ST_PUSH: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef IKAOPLL_ACC_DCBLOCK_EN
    localparam int ACC_W = 17 + DC_SHIFT;

    logic signed [ACC_W-1:0]  dc_acc;
    logic signed [16:0]       dc_est;

    // The top 17 bits of the accumulator are dc_acc >>> DC_SHIFT.
    assign dc_est = dc_acc[DC_SHIFT +: 17];
    assign y_nxt  = $signed({{2{x_p0[15]}}, x_p0}) - $signed({dc_est[16], dc_est});

    // DC estimate integrates the saturated output, updated as the sample leaves SAT.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST)                dc_acc <= '0;
        else if (state == ST_SAT) dc_acc <= dc_acc + ACC_W'(ys_nxt);
    end
`else
    logic unused_dc_shift;

    assign y_nxt           = $signed({{2{x_p0[15]}}, x_p0});
    assign unused_dc_shift = ^DC_SHIFT;
`endif

    assign ys_nxt = sat16(y_p1);

    // Sample datapath; the FSM state qualifies each stage, so no reset is needed here.
    always_ff @(posedge i_EMUCLK) begin
        // p0: captured accumulator sample
        if (capture && state == ST_IDLE) x_p0 <= i_ACC_SIGNED;
        // p1: DC-removed sample at 18 bits, cannot wrap
        if (state == ST_FILT) y_p1 <= y_nxt;
        // p2: saturated sample ready for the FIFO
        if (state == ST_SAT) ys_p2 <= ys_nxt;
    end

    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign push_req   = (state == ST_PUSH);
    assign pop        = ~fifo_empty & i_SAMPLE_READY;
    // A full FIFO can still take the sample when the head leaves in the same clock.
    assign push       = push_req & (~fifo_full | pop);
    assign drop       = push_req & fifo_full & ~pop;

    // FIFO storage, cleared on reset so nothing stale reappears.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (push) begin
            fifo_mem[wr_ptr] <= ys_p2;
        end
    end

    // FIFO pointers wrap naturally at the power-of-two depth; level tracks occupancy.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow: a lost sample wins over a clear in the same clock.
    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST)                                   o_OVERFLOW <= 1'b0;
        else if (drop || (capture && state != ST_IDLE)) o_OVERFLOW <= 1'b1;
        else if (i_OVF_CLR)                          o_OVERFLOW <= 1'b0;
    end

    assign o_SAMPLE_VALID = ~fifo_empty;
    assign o_SAMPLE       = fifo_empty ? 16'sd0 : fifo_mem[rd_ptr];
    assign o_FIFO_LEVEL   = level;

endmodule

// File: tb/tb_ikaopll_acc_postproc.sv
// Bench for ikaopll_acc_postproc: directed vector table, corner sequences and random
// traffic checked every cycle against a queue-based reference model.
module tb_ikaopll_acc_postproc;

    localparam int DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               strb = 1'b0;
    logic               ready = 1'b0;
    logic               clr = 1'b0;
    logic signed [15:0] din = '0;

    logic signed [15:0] s9, s0;
    logic               v9, v0, ovf9, ovf0;
    logic [2:0]         lvl9, lvl0;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    ikaopll_acc_postproc #(.FIFO_DEPTH(DEPTH), .DC_SHIFT(9)) dut9 (
        .i_EMUCLK(clk), .i_RST(rst), .i_ACC_SIGNED_STRB(strb), .i_ACC_SIGNED(din),
        .o_SAMPLE(s9), .o_SAMPLE_VALID(v9), .i_SAMPLE_READY(ready),
        .o_FIFO_LEVEL(lvl9), .o_OVERFLOW(ovf9), .i_OVF_CLR(clr)
    );

    ikaopll_acc_postproc #(.FIFO_DEPTH(DEPTH), .DC_SHIFT(0)) dut0 (
        .i_EMUCLK(clk), .i_RST(rst), .i_ACC_SIGNED_STRB(strb), .i_ACC_SIGNED(din),
        .o_SAMPLE(s0), .o_SAMPLE_VALID(v0), .i_SAMPLE_READY(ready),
        .o_FIFO_LEVEL(lvl0), .o_OVERFLOW(ovf0), .i_OVF_CLR(clr)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int clamp16(input longint v);
        if (v > 32767)       return 32767;
        else if (v < -32768) return -32768;
        else                 return int'(v);
    endfunction

    // Output of the filter for input x given the running DC sum acc and shift k.
    function automatic int filt(input int x, input int k, input longint acc);
`ifdef IKAOPLL_ACC_DCBLOCK_EN
        return clamp16(longint'(x) - (acc >>> k));
`else
        return clamp16(longint'(x) + 0 * acc + 0 * k);
`endif
    endfunction

    typedef struct { int y9; int y0; } samp_t;

    samp_t  mq[$];
    samp_t  pend;
    int     m_busy = 0;     // clocks until the in-flight sample reaches the FIFO
    bit     m_strb_z = 1'b1;
    bit     m_ovf = 1'b0;
    longint acc9 = 0, acc0 = 0;

    task automatic model_step();
        bit cap, pop, busy, do_push, full, set_ovf;
        int sz, x;
        sz      = mq.size();
        cap     = strb && !m_strb_z;
        busy    = (m_busy != 0);
        do_push = (m_busy == 1);
        pop     = (sz > 0) && ready;
        full    = (sz == DEPTH);
        set_ovf = 1'b0;
        if (pop) void'(mq.pop_front());
        if (do_push) begin
            if (full && !pop) set_ovf = 1'b1;
            else              mq.push_back(pend);
        end
        if (m_busy > 0) m_busy--;
        if (cap) begin
            if (busy) set_ovf = 1'b1;
            else begin
                x = int'(din);
                pend.y9 = filt(x, 9, acc9);
                pend.y0 = filt(x, 0, acc0);
                acc9 += pend.y9;
                acc0 += pend.y0;
                m_busy = 3;
            end
        end
        if (set_ovf)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_strb_z = strb;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_busy = 0; m_strb_z = 1'b1; m_ovf = 1'b0; acc9 = 0; acc0 = 0;
            end else begin
                model_step();
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("valid9",  int'(v9),   int'(mq.size() > 0));
            chk("valid0",  int'(v0),   int'(mq.size() > 0));
            chk("sample9", int'(s9),   (mq.size() > 0) ? mq[0].y9 : 0);
            chk("sample0", int'(s0),   (mq.size() > 0) ? mq[0].y0 : 0);
            chk("level9",  int'(lvl9), mq.size());
            chk("level0",  int'(lvl0), mq.size());
            chk("ovf9",    int'(ovf9), int'(m_ovf));
            chk("ovf0",    int'(ovf0), int'(m_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // One strobe pulse; returns at the negedge where the pushed sample is visible.
    task automatic cap(input logic signed [15:0] x, input bit clr_at_push);
        din = x; strb = 1'b1;
        tick();
        tick(); strb = 1'b0;
        tick(); clr = clr_at_push;
        tick(); clr = 1'b0;
    endtask

    task automatic pop1();
        ready = 1'b1; tick(); ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid9"}, int'(v9), 0);
        chk({tag, "_valid0"}, int'(v0), 0);
        chk({tag, "_sample9"}, int'(s9), 0);
        chk({tag, "_sample0"}, int'(s0), 0);
        chk({tag, "_level"}, int'(lvl9), 0);
        chk({tag, "_ovf"}, int'(ovf9), 0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        tick();
        chk_reset_outputs("reset");
        #2 rst = 1'b0;
        tick();
    endtask

    typedef struct { int x; int e9; int e0; } vec_t;

    vec_t   vecs[7];
    int     xs[7];
    int     e9[7], e0[7];
    longint ra9, ra0;

    initial begin
`ifdef IKAOPLL_ACC_DCBLOCK_EN
        vecs[0] = '{1000, 1000, 1000};
        vecs[1] = '{1000, 999, 0};
        vecs[2] = '{-5000, -5003, -6000};
        vecs[3] = '{32767, 32767, 32767};
        vecs[4] = '{-32768, -32768, -32768};
        vecs[5] = '{0, 6, 5001};
        vecs[6] = '{4660, 4666, 4660};
`else
        vecs[0] = '{1000, 1000, 1000};
        vecs[1] = '{1000, 1000, 1000};
        vecs[2] = '{-5000, -5000, -5000};
        vecs[3] = '{32767, 32767, 32767};
        vecs[4] = '{-32768, -32768, -32768};
        vecs[5] = '{0, 0, 0};
        vecs[6] = '{4660, 4660, 4660};
`endif
        tick(2);
        chk_reset_outputs("por");
        #2 rst = 1'b0;
        tick();

        // Table: each capture visible after 4 clocks, one pop empties the FIFO.
        for (int i = 0; i < 7; i++) begin
            cap(16'(vecs[i].x), 1'b0);
            chk("tbl_valid", int'(v9), 1);
            chk("tbl_sample9", int'(s9), vecs[i].e9);
            chk("tbl_sample0", int'(s0), vecs[i].e0);
            chk("tbl_level", int'(lvl9), 1);
            pop1();
            chk("tbl_pop_valid", int'(v9), 0);
            chk("tbl_pop_sample", int'(s9), 0);
        end

        // Saturation at the extremes, then a zero sample exposes dc_acc = -1.
        do_reset();
        cap(16'sd32767, 1'b0);
        chk("sat_hi9", int'(s9), 32767);
        chk("sat_hi0", int'(s0), 32767);
        pop1();
        cap(-16'sd32768, 1'b0);
        chk("sat_lo9", int'(s9), -32768);
        chk("sat_lo0", int'(s0), -32768);
        pop1();
        cap(16'sd0, 1'b0);
`ifdef IKAOPLL_ACC_DCBLOCK_EN
        chk("dcacc_m1_9", int'(s9), 1);
        chk("dcacc_m1_0", int'(s0), 1);
`else
        chk("dcacc_m1_9", int'(s9), 0);
        chk("dcacc_m1_0", int'(s0), 0);
`endif
        pop1();

        // Overflow: READY low, five captures into a four-entry FIFO.
        do_reset();
        ra9 = 0; ra0 = 0;
        for (int i = 0; i < 7; i++) begin
            xs[i] = 100 + 37 * i;
            e9[i] = filt(xs[i], 9, ra9); ra9 += e9[i];
            e0[i] = filt(xs[i], 0, ra0); ra0 += e0[i];
        end
        for (int i = 0; i < 5; i++) cap(16'(xs[i]), 1'b0);
        chk("full_level", int'(lvl9), 4);
        chk("full_ovf", int'(ovf9), 1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("ovf_clr", int'(ovf9), 0);
        cap(16'(xs[5]), 1'b1);
        chk("ovf_set_wins", int'(ovf9), 1);
        chk("ovf_set_level", int'(lvl9), 4);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("ovf_clr2", int'(ovf9), 0);
        // Full FIFO with READY high exactly at the push clock.
        din = 16'(xs[6]); strb = 1'b1;
        tick();
        tick(); strb = 1'b0;
        tick(); ready = 1'b1;
        tick(); ready = 1'b0;
        chk("pushpop_level", int'(lvl9), 4);
        chk("pushpop_ovf", int'(ovf9), 0);
        foreach (xs[i]) begin
            if (i == 1 || i == 2 || i == 3 || i == 6) begin
                chk("order9", int'(s9), e9[i]);
                chk("order0", int'(s0), e0[i]);
                pop1();
            end
        end
        chk("drained", int'(v9), 0);

        // A strobe edge while busy is lost and flagged.
        do_reset();
        din = 16'sd500; strb = 1'b1;
        tick(); strb = 1'b0;
        tick(); strb = 1'b1;
        tick();
        tick(); strb = 1'b0;
        chk("busy_ovf", int'(ovf9), 1);
        chk("busy_level", int'(lvl9), 1);
        chk("busy_sample", int'(s9), 500);
        tick(4);
        chk("busy_level_after", int'(lvl9), 1);
        pop1();

        // Reset while a sample is in FILT: nothing is pushed, dc_acc is cleared.
        do_reset();
        cap(16'sd700, 1'b0);
        chk("pre_rst_level", int'(lvl9), 1);
        din = 16'sd800; strb = 1'b1;
        tick();
        #2 rst = 1'b1; strb = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        #2 rst = 1'b0;
        tick(5);
        chk("midrst_level", int'(lvl9), 0);
        cap(16'sd1000, 1'b0);
        chk("midrst_dc9", int'(s9), 1000);
        chk("midrst_dc0", int'(s0), 1000);
        pop1();

        // Strobe high through reset release is not a capture.
        strb = 1'b1;
        #2 rst = 1'b1;
        tick();
        #2 rst = 1'b0;
        tick(6);
        chk("held_strb_level", int'(lvl9), 0);
        chk("held_strb_valid", int'(v9), 0);
        strb = 1'b0;
        tick();
        cap(16'sh1234, 1'b0);
        chk("refire9", int'(s9), 16'h1234);
        chk("refire0", int'(s0), 16'h1234);
        pop1();

        // Random traffic, checked by the per-cycle model comparison.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!strb) begin
                case ($urandom_range(0, 5))
                    0:       din = 16'sh7FFF;
                    1:       din = 16'sh8000;
                    default: din = 16'($urandom);
                endcase
                strb = ($urandom_range(0, 3) == 0);
            end else begin
                strb = ($urandom_range(0, 1) == 0);
            end
            ready = ($urandom_range(0, 2) == 0);
            clr   = ($urandom_range(0, 19) == 0);
            tick();
        end
        strb = 1'b0; ready = 1'b0; clr = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ikaopll_acc_postproc.md
# ikaopll_acc_postproc

Post-processing stage that sits directly downstream of the OPLL DAC accumulator. It consumes the per-frame 16-bit signed accumulated sample and its strobe. It optionally removes DC with a first-order high-pass and saturates the result. Finished samples are buffered in a small FIFO and handed to the host audio path over a valid/ready handshake.

## Interface
Parameters:
- FIFO_DEPTH, default 4: FIFO entries. Must be a power of two and ≥ 2.
- DC_SHIFT, default 9: high-pass pole shift K, so the pole is 1 − 2^-K. Legal range 0–15.

Ports:
- i_EMUCLK  in  1  emulator master clock; the only clock in the block.
- i_RST  in  1  reset, asynchronous, active-high.
- i_ACC_SIGNED_STRB  in  1  frame strobe from the accumulator DAC. Level signal; a new sample is marked by its rising edge.
- i_ACC_SIGNED  in  16  signed accumulated sample. Stable while the strobe is high.
- o_SAMPLE  out  16  signed FIFO head sample. Reads 0 when o_SAMPLE_VALID is low.
- o_SAMPLE_VALID  out  1  FIFO not empty.
- i_SAMPLE_READY  in  1  consumer accepts the head sample this cycle.
- o_FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- o_OVERFLOW  out  1  sticky flag for a dropped sample.
- i_OVF_CLR  in  1  clears o_OVERFLOW.

## Operation
- Edge detect: register strb_z. A capture occurs when i_ACC_SIGNED_STRB & ~strb_z; the capture latches x = i_ACC_SIGNED.
- strb_z resets to 1, so a strobe held high across reset release is not captured.
- FSM states: IDLE → FILT → SAT → PUSH → IDLE, one clock per state. A capture moves the FSM from IDLE to FILT.
- A capture edge arriving in any state other than IDLE is ignored and sets o_OVERFLOW.
- FILT (macro on): est = dc_acc >>> DC_SHIFT; y = x − est, computed at 17 bits or wider with no wrap.
- FILT (macro off): y = x.
- SAT: ys = clamp(y, −32768, 32767).
- SAT (macro on): dc_acc <= dc_acc + sign-extended ys. dc_acc is a signed register of 17+DC_SHIFT bits and resets to 0.
- PUSH: write ys into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the sample is dropped and o_OVERFLOW is set.
  - A push and a pop in the same cycle at full are both performed; level is unchanged.
- Pop: occurs when o_SAMPLE_VALID & i_SAMPLE_READY. i_SAMPLE_READY while empty has no effect.
- o_FIFO_LEVEL: +1 on push only, −1 on pop only, unchanged on both. It never exceeds FIFO_DEPTH and never goes below 0.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH.
- o_OVERFLOW: set has priority over i_OVF_CLR in the same cycle.
- Reset mid-operation: the FSM returns to IDLE, in-flight samples are discarded, FIFO contents and pointers are cleared, and dc_acc returns to 0.

## Timing
- Reset values:
  - o_SAMPLE = 0, o_SAMPLE_VALID = 0, o_FIFO_LEVEL = 0, o_OVERFLOW = 0.
  - FSM in IDLE, strb_z = 1, dc_acc = 0.
- Capture edge E0: x latched, FSM goes to FILT.
- E1: y registered.
- E2: ys registered; dc_acc updated.
- E3: FIFO write. o_SAMPLE_VALID and o_SAMPLE update after E3 if the FIFO was empty.
- Latency: capture to output visible is 4 clocks.
- Pop takes effect at the clock edge where VALID & READY are high. The next head entry (or 0 when empty) is visible after that edge.
- Throughput: one sample per 4 clocks. The upstream strobe period (≥ 32 phi1 cycles) never violates this in normal operation.

## Configuration
- Macro IKAOPLL_ACC_DCBLOCK_EN.
- Defined: the DC-removal high-pass in FILT is compiled in, along with the dc_acc register and its update.
- Undefined: y = x, no dc_acc register exists, and DC_SHIFT is unused. The SAT stage remains, so latency stays at 4 clocks.

## Test plan
- Macro off: strobe rises with i_ACC_SIGNED = 16'h1234 → o_SAMPLE_VALID = 1 and o_SAMPLE = 16'h1234 after the 4th clock; READY pulse → VALID = 0 and o_SAMPLE = 0.
- Macro on, DC_SHIFT = 9, from reset: two captures of 1000 → samples 1000 then 999 (est = 1000 >>> 9 = 1).
- Macro on, DC_SHIFT = 0: capture 32767, then capture −32768 → outputs 32767 then −32768 (y = −65535 saturated); dc_acc = −1 afterwards.
- READY held low, FIFO_DEPTH = 4, 5 captures → level = 4 and o_OVERFLOW = 1; pops return the first 4 samples in order. i_OVF_CLR clears the flag; i_OVF_CLR asserted in the same cycle as a new drop leaves the flag at 1.
- Full FIFO with READY high during a PUSH → level stays 4 and o_OVERFLOW stays 0.
- Reset cases:
  - Assert i_RST during FILT → the sample is never pushed and all outputs return to reset values.
  - Strobe held high through reset release → no capture occurs until the strobe falls and rises again.
